// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared 640x480 timing constants, coordinate/RGB widths, the decoder
//   state encoding and a small window-compare helper used by the VGA
//   receive-side decoder (vga_sync_decoder) and its period meter.
package vga_timing_pkg;

  // 640x480 @ 25 MHz timing
  localparam int VGA_H_TOTAL  = 800;
  localparam int VGA_V_TOTAL  = 521;
  localparam int VGA_H_BP     = 144;  // hsync fall -> first active pixel
  localparam int VGA_V_BP     = 31;   // vsync fall -> first active line
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_V_ACTIVE = 480;

  // datapath widths
  localparam int X_W    = 10;
  localparam int Y_W    = 10;
  localparam int RGB_W  = 9;
  localparam int HCNT_W = 11;
  localparam int VCNT_W = 10;
  localparam int GOOD_W = 4;   // good-frame counter, holds LOCK_FRAMES up to 15

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } dec_state_e;

  // lo <= v < lo+n
  function automatic logic in_win(input logic [11:0] v,
                                  input logic [11:0] lo,
                                  input logic [11:0] n);
    return (v >= lo) && (v < lo + n);
  endfunction

endpackage

// File: rtl/vga_period_meter.sv
// vga_period_meter
//   Falling-edge detector plus saturating period counter for one sync
//   signal. The counter advances on 'step' and restarts at the first step
//   that coincides with, or follows, a detected falling edge of 'sync'.
//   The period ending at a restart (count+1) is loaded into 'meas' once the
//   meter has seen one previous restart since it was last flushed.
//   Ports:
//     dclk, clr    pixel clock, async active-high reset
//     sync         stage-1 registered sync level (active-low)
//     step         count enable (1 for pixel counting, line tick for lines)
//     flush        disarm: the next restart is not measured
//     fall         falling edge of sync detected this cycle
//     cnt          count for the current cycle (0 on a restart cycle)
//     meas_ld      a measured period is being loaded this cycle
//     period       period ending this cycle, valid with meas_ld
//     meas         last measured period
module vga_period_meter #(
  parameter int W = 11
) (
  input  logic         dclk,
  input  logic         clr,
  input  logic         sync,
  input  logic         step,
  input  logic         flush,
  output logic         fall,
  output logic [W-1:0] cnt,
  output logic         meas_ld,
  output logic [W-1:0] period,
  output logic [W-1:0] meas
);

  localparam logic [W-1:0] CMAX = '1;

  logic         sync_d;
  logic         pend_q;   // edge seen, waiting for the next step
  logic         armed_q;  // a restart has occurred since flush
  logic         restart;
  logic [W-1:0] cnt_q;

  assign fall    = sync_d & ~sync;
  assign restart = step & (pend_q | fall);
  assign meas_ld = restart & armed_q;
  assign period  = (cnt_q == CMAX) ? CMAX : cnt_q + 1'b1;

  always_comb begin
    cnt = cnt_q;
    if (restart)                   cnt = '0;
    else if (step && cnt_q != CMAX) cnt = cnt_q + 1'b1;
  end

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      sync_d  <= 1'b0;
      pend_q  <= 1'b0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      meas    <= '0;
    end else begin
      sync_d <= sync;
      cnt_q  <= cnt;
      pend_q <= step ? 1'b0 : (pend_q | fall);
      if (flush)        armed_q <= 1'b0;
      else if (restart) armed_q <= 1'b1;
      if (meas_ld) meas <= period;
    end
  end

endmodule

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
//   Receive-side VGA timing decoder. Registers hsync/vsync/RGB once,
//   recovers pixel coordinates, measures line/frame periods, and locks after
//   LOCK_FRAMES consecutive conforming frames. Output stage is registered:
//   RGB at the pins in cycle t appears on pix_rgb in t+2 with its pix_x/y.
//   Build option: define FRAME_CHECKSUM_EN to add frame_sum/frame_sum_vld,
//   a 16-bit wrap-around sum of pix_rgb over each locked frame.
//   Ports:
//     dclk, clr             pixel clock, async active-high reset
//     hsync, vsync          active-low syncs
//     red, green, blue      3-bit colour inputs
//     pix_x, pix_y, pix_rgb active-area coordinates and aligned colour
//     pix_valid, sof, eol   qualifiers / frame and line markers
//     locked, err           lock status, one-cycle violation pulse
//     h_meas, v_meas        last measured line period / frame line count
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL     = VGA_H_TOTAL,
  parameter int V_TOTAL     = VGA_V_TOTAL,
  parameter int H_BP        = VGA_H_BP,
  parameter int V_BP        = VGA_V_BP,
  parameter int H_ACTIVE    = VGA_H_ACTIVE,
  parameter int V_ACTIVE    = VGA_V_ACTIVE,
  parameter int LOCK_FRAMES = 2
) (
  input  logic              dclk,
  input  logic              clr,
  input  logic              hsync,
  input  logic              vsync,
  input  logic [2:0]        red,
  input  logic [2:0]        green,
  input  logic [2:0]        blue,
  output logic [X_W-1:0]    pix_x,
  output logic [Y_W-1:0]    pix_y,
  output logic [RGB_W-1:0]  pix_rgb,
  output logic              pix_valid,
  output logic              sof,
  output logic              eol,
  output logic              locked,
  output logic              err,
  output logic [HCNT_W-1:0] h_meas,
  output logic [VCNT_W-1:0] v_meas
`ifdef FRAME_CHECKSUM_EN
  ,
  output logic [15:0]       frame_sum,
  output logic              frame_sum_vld
`endif
);

  // ---------------- input stage ----------------
  logic             hs_s1, vs_s1;
  logic [RGB_W-1:0] rgb_s1;

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      hs_s1  <= 1'b0;
      vs_s1  <= 1'b0;
      rgb_s1 <= '0;
    end else begin
      hs_s1  <= hsync;
      vs_s1  <= vsync;
      rgb_s1 <= {red, green, blue};
    end
  end

  // ---------------- period meters ----------------
  dec_state_e        st_q, st_n;
  logic              flush;
  logic              h_fall, v_fall, h_ld, v_ld;
  logic [HCNT_W-1:0] h_cnt, h_period;
  logic [VCNT_W-1:0] v_cnt, v_period;

  // Measurements stay disarmed while searching; the vsync fall that leaves
  // SEARCH is allowed to arm both meters so the first frame can count.
  assign flush = (st_q == SEARCH) & ~v_fall;

  vga_period_meter #(.W(HCNT_W)) u_hmeter (
    .dclk    (dclk),
    .clr     (clr),
    .sync    (hs_s1),
    .step    (1'b1),
    .flush   (flush),
    .fall    (h_fall),
    .cnt     (h_cnt),
    .meas_ld (h_ld),
    .period  (h_period),
    .meas    (h_meas)
  );

  // Line counter: steps on each hsync fall, restarts on the first hsync fall
  // at or after a vsync fall.
  vga_period_meter #(.W(VCNT_W)) u_vmeter (
    .dclk    (dclk),
    .clr     (clr),
    .sync    (vs_s1),
    .step    (h_fall),
    .flush   (flush),
    .fall    (v_fall),
    .cnt     (v_cnt),
    .meas_ld (v_ld),
    .period  (v_period),
    .meas    (v_meas)
  );

  // ---------------- lock FSM ----------------
  logic              h_bad, v_bad, tout;
  logic              bad_q, bad_n;     // current frame already saw a bad line
  logic [GOOD_W-1:0] good_q, good_n, good_inc;
  logic              err_n;

  assign h_bad    = h_ld & (h_period != HCNT_W'(H_TOTAL));
  assign v_bad    = v_ld & (v_period != VCNT_W'(V_TOTAL));
  assign tout     = (h_cnt == HCNT_W'(2 * H_TOTAL));
  assign good_inc = good_q + 1'b1;

  always_comb begin
    st_n   = st_q;
    good_n = good_q;
    bad_n  = bad_q;
    err_n  = 1'b0;
    case (st_q)
      SEARCH: begin
        if (v_fall) begin
          st_n   = MEASURE;
          good_n = '0;
          bad_n  = 1'b0;
        end
      end
      MEASURE: begin
        if (h_bad) begin
          good_n = '0;
          bad_n  = 1'b1;
        end
        if (v_ld) begin
          bad_n = 1'b0;
          if (v_bad || h_bad || bad_q) good_n = '0;
          else begin
            good_n = good_inc;
            if (good_inc == GOOD_W'(LOCK_FRAMES)) st_n = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (v_ld) bad_n = 1'b0;
        if (h_bad || v_bad) begin
          err_n  = 1'b1;
          st_n   = MEASURE;
          good_n = '0;
          // a bad line mid-frame spoils the rest of that frame
          if (h_bad && !v_ld) bad_n = 1'b1;
        end
      end
      default: st_n = SEARCH;
    endcase
    // lost hsync overrides everything
    if (tout) begin
      st_n   = SEARCH;
      good_n = '0;
      bad_n  = 1'b0;
      err_n  = (st_q != SEARCH);
    end
  end

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      st_q   <= SEARCH;
      good_q <= '0;
      bad_q  <= 1'b0;
    end else begin
      st_q   <= st_n;
      good_q <= good_n;
      bad_q  <= bad_n;
    end
  end

  assign locked = (st_q == LOCKED);

  // ---------------- active area / output stage ----------------
  logic              act, pv_n, sof_n, eol_n;
  logic [HCNT_W-1:0] hx;
  logic [VCNT_W-1:0] vy;
  logic [X_W-1:0]    x_n;
  logic [Y_W-1:0]    y_n;

  assign act   = in_win({1'b0, h_cnt}, 12'(H_BP), 12'(H_ACTIVE)) &
                 in_win({2'b0, v_cnt}, 12'(V_BP), 12'(V_ACTIVE));
  assign hx    = h_cnt - HCNT_W'(H_BP);
  assign vy    = v_cnt - VCNT_W'(V_BP);
  assign x_n   = act ? hx[X_W-1:0] : '0;
  assign y_n   = act ? vy[Y_W-1:0] : '0;
  assign pv_n  = act & (st_q == LOCKED);
  assign sof_n = pv_n & (x_n == '0) & (y_n == '0);
  assign eol_n = pv_n & (x_n == X_W'(H_ACTIVE - 1));

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      pix_x     <= '0;
      pix_y     <= '0;
      pix_rgb   <= '0;
      pix_valid <= 1'b0;
      sof       <= 1'b0;
      eol       <= 1'b0;
      err       <= 1'b0;
    end else begin
      pix_x     <= x_n;
      pix_y     <= y_n;
      pix_rgb   <= rgb_s1;
      pix_valid <= pv_n;
      sof       <= sof_n;
      eol       <= eol_n;
      err       <= err_n;
    end
  end

`ifdef FRAME_CHECKSUM_EN
  // Accumulates on the pre-register view so frame_sum_vld lines up with the
  // eol of the last active row on the outputs.
  logic [15:0] acc_q, acc_add;

  assign acc_add = acc_q + {7'd0, rgb_s1};

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      acc_q         <= '0;
      frame_sum     <= '0;
      frame_sum_vld <= 1'b0;
    end else begin
      frame_sum_vld <= 1'b0;
      if (st_q != LOCKED) acc_q <= '0;
      else if (sof_n)     acc_q <= {7'd0, rgb_s1};
      else if (pv_n)      acc_q <= acc_add;
      if (eol_n && y_n == Y_W'(V_ACTIVE - 1)) begin
        frame_sum     <= acc_add;
        frame_sum_vld <= 1'b1;
      end
    end
  end
`endif

endmodule
